// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings, frame width and
// the baud divider computation used to size the oversampling tick.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_e;

  localparam int DATA_BITS = 8;

  // Rounded clocks-per-tick, never below 1 so the tick counter always advances.
  function automatic int calc_div(int clk_hz, int baud, int oversample);
    int d;
    d = (clk_hz + (baud * oversample) / 2) / (baud * oversample);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte handshake between the UART receiver and its consumer.
interface uart_rx_if;
  import uart_pkg::*;

  // rx_valid rises with a byte in rx_data and both hold until a cycle where
  // rx_valid && rx_ready, which consumes the byte; framing_err/overrun are 1-cycle pulses.
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 framing_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, framing_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, framing_err, overrun,
    output rx_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, held off and
// zeroed while restart is high so the first tick lands DIV clocks after release.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised line, falling-edge start detect, mid-bit
// sampling on oversampled ticks, and a single-entry valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         UART_RX,
  uart_rx_if.master    rx,
  output uart_state_e  state_dbg
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [SW-1:0] SAMPLE_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);

  uart_state_e          state, state_nxt;
  logic                 sync1, sync2, line_prev;
  logic                 line, fall, tick, restart;
  logic [SW-1:0]        sample_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift, data_q;
  logic                 valid_q, ferr_q, ovr_q;
  logic                 samp_clr, samp_inc, bit_clr, bit_shift, byte_done, frame_bad;

  assign line      = sync2;
  assign fall      = line_prev && !line;
  assign restart   = (state == IDLE);
  assign state_dbg = state;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (CLOCK_50),
    .rst     (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (fall) state_nxt = START;
      START:     if (tick && sample_cnt == SAMPLE_MID) state_nxt = line ? IDLE : DATA;
      DATA:      if (tick && sample_cnt == SAMPLE_LAST && bit_cnt == BIT_LAST) state_nxt = STOP;
      STOP:      if (tick && sample_cnt == SAMPLE_LAST) state_nxt = line ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (line) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    samp_clr  = 1'b0;
    samp_inc  = 1'b0;
    bit_clr   = 1'b0;
    bit_shift = 1'b0;
    byte_done = 1'b0;
    frame_bad = 1'b0;
    case (state)
      IDLE: begin
        samp_clr = 1'b1;
        bit_clr  = 1'b1;
      end
      START: if (tick) begin
        if (sample_cnt == SAMPLE_MID) samp_clr = 1'b1;
        else                          samp_inc = 1'b1;
      end
      DATA: if (tick) begin
        if (sample_cnt == SAMPLE_LAST) begin
          samp_clr  = 1'b1;
          bit_shift = 1'b1;
        end else begin
          samp_inc = 1'b1;
        end
      end
      STOP: if (tick) begin
        if (sample_cnt == SAMPLE_LAST) begin
          samp_clr  = 1'b1;
          byte_done = line;
          frame_bad = !line;
        end else begin
          samp_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      line_prev  <= 1'b1;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1     <= UART_RX;
      sync2     <= sync1;
      line_prev <= sync2;

      if (samp_clr)      sample_cnt <= '0;
      else if (samp_inc) sample_cnt <= sample_cnt + SW'(1);

      if (bit_clr)        bit_cnt <= '0;
      else if (bit_shift) bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);

      // LSB arrives first, so shift in from the top.
      if (bit_shift) shift <= {line, shift[DATA_BITS-1:1]};

      ferr_q <= frame_bad;
      ovr_q  <= byte_done && valid_q && !rx.rx_ready;

      // A completing byte may replace a held one only if it is consumed this cycle.
      if (byte_done) begin
        if (!valid_q || rx.rx_ready) begin
          data_q  <= shift;
          valid_q <= 1'b1;
        end
      end else if (valid_q && rx.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx.rx_data     = data_q;
  assign rx.rx_valid    = valid_q;
  assign rx.framing_err = ferr_q;
  assign rx.overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at DIV = 1 (16 clocks per bit): serial driver tasks, a
// handshake monitor that pops an expected-byte queue, and per-scenario checks.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLKS = 16;
  // Posedges from driving the start bit to the edge that loads the byte.
  localparam int DONE_LAT = 155;

  logic        clk;
  logic        reset;
  logic        line;
  uart_state_e state_dbg;

  uart_rx_if rx ();

  uart_rx #(
    .CLK_HZ     (1_600_000),
    .BAUD       (100_000),
    .OVERSAMPLE (16)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .UART_RX   (line),
    .rx        (rx),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int tests_run = 0;
  int failed    = 0;
  int rise_cnt  = 0;
  int ferr_cnt  = 0;
  int ovr_cnt   = 0;
  logic prev_valid = 1'b0;
  int s_rise, s_ferr, s_ovr;

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      line = frame[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  task automatic snap();
    s_rise = rise_cnt;
    s_ferr = ferr_cnt;
    s_ovr  = ovr_cnt;
  endtask

  // scoreboard monitor: sees the values the DUT will act on at the next posedge
  task automatic monitor();
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (rx.rx_valid && !prev_valid) rise_cnt++;
        prev_valid = rx.rx_valid;
        if (rx.framing_err) ferr_cnt++;
        if (rx.overrun)     ovr_cnt++;
        if (rx.rx_valid && rx.rx_ready) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL unexpected_byte: got %02h, required no byte", rx.rx_data);
          end else begin
            exp = exp_q.pop_front();
            if (rx.rx_data !== exp) begin
              failed++;
              $display("FAIL byte_data: got %02h, required %02h", rx.rx_data, exp);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    line = 1'b1;
    rx.rx_ready = 1'b1;
    idle(3);
    #1;
    tests_run++; if (rx.rx_data !== 8'h00)  begin failed++; $display("FAIL reset_data: got %02h, required 00", rx.rx_data); end
    tests_run++; if (rx.rx_valid !== 1'b0)  begin failed++; $display("FAIL reset_valid: got %b, required 0", rx.rx_valid); end
    tests_run++; if (rx.framing_err !== 1'b0) begin failed++; $display("FAIL reset_ferr: got %b, required 0", rx.framing_err); end
    tests_run++; if (rx.overrun !== 1'b0)   begin failed++; $display("FAIL reset_ovr: got %b, required 0", rx.overrun); end
    tests_run++; if (state_dbg !== IDLE)    begin failed++; $display("FAIL reset_state: got %0d, required %0d", state_dbg, IDLE); end
    @(negedge clk);
    reset = 1'b0;
    idle(5);
  endtask

  task automatic test_basic();
    snap();
    exp_q.push_back(8'h55); send_byte(8'h55, 1'b1);
    exp_q.push_back(8'hA3); send_byte(8'hA3, 1'b1);
    idle(40);
    tests_run++; if (exp_q.size() != 0)      begin failed++; $display("FAIL basic_drain: got %0d pending, required 0", exp_q.size()); end
    tests_run++; if (rise_cnt - s_rise != 2) begin failed++; $display("FAIL basic_rises: got %0d, required 2", rise_cnt - s_rise); end
    tests_run++; if (ferr_cnt - s_ferr != 0) begin failed++; $display("FAIL basic_ferr: got %0d, required 0", ferr_cnt - s_ferr); end
    tests_run++; if (ovr_cnt - s_ovr != 0)   begin failed++; $display("FAIL basic_ovr: got %0d, required 0", ovr_cnt - s_ovr); end
  endtask

  task automatic test_glitch();
    snap();
    line = 1'b0; idle(5);
    line = 1'b1; idle(30);
    tests_run++; if (rise_cnt - s_rise != 0) begin failed++; $display("FAIL glitch_rises: got %0d, required 0", rise_cnt - s_rise); end
    exp_q.push_back(8'h0F); send_byte(8'h0F, 1'b1);
    idle(40);
    tests_run++; if (exp_q.size() != 0)      begin failed++; $display("FAIL glitch_drain: got %0d pending, required 0", exp_q.size()); end
    tests_run++; if (rise_cnt - s_rise != 1) begin failed++; $display("FAIL glitch_rises_after: got %0d, required 1", rise_cnt - s_rise); end
    tests_run++; if (ferr_cnt - s_ferr != 0 || ovr_cnt - s_ovr != 0) begin failed++; $display("FAIL glitch_pulses: got ferr %0d ovr %0d, required 0 0", ferr_cnt - s_ferr, ovr_cnt - s_ovr); end
  endtask

  task automatic test_framing();
    snap();
    send_byte(8'h81, 1'b0);
    idle(40);
    line = 1'b1; idle(16);
    tests_run++; if (rise_cnt - s_rise != 0) begin failed++; $display("FAIL frame_no_valid: got %0d rises, required 0", rise_cnt - s_rise); end
    exp_q.push_back(8'h3C); send_byte(8'h3C, 1'b1);
    idle(40);
    tests_run++; if (ferr_cnt - s_ferr != 1) begin failed++; $display("FAIL frame_ferr: got %0d, required 1", ferr_cnt - s_ferr); end
    tests_run++; if (exp_q.size() != 0)      begin failed++; $display("FAIL frame_drain: got %0d pending, required 0", exp_q.size()); end
    tests_run++; if (ovr_cnt - s_ovr != 0)   begin failed++; $display("FAIL frame_ovr: got %0d, required 0", ovr_cnt - s_ovr); end
  endtask

  task automatic test_overrun();
    snap();
    rx.rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(30);
    #1;
    tests_run++; if (ovr_cnt - s_ovr != 1) begin failed++; $display("FAIL ovr_count: got %0d, required 1", ovr_cnt - s_ovr); end
    tests_run++; if (rx.rx_data !== 8'h11) begin failed++; $display("FAIL ovr_data: got %02h, required 11", rx.rx_data); end
    tests_run++; if (rx.rx_valid !== 1'b1) begin failed++; $display("FAIL ovr_valid: got %b, required 1", rx.rx_valid); end
    @(negedge clk);
    rx.rx_ready = 1'b1;
    @(negedge clk);
    #2;
    tests_run++; if (rx.rx_valid !== 1'b0) begin failed++; $display("FAIL ovr_clear: got %b, required 0", rx.rx_valid); end
    tests_run++; if (exp_q.size() != 0)    begin failed++; $display("FAIL ovr_drain: got %0d pending, required 0", exp_q.size()); end
    tests_run++; if (ferr_cnt - s_ferr != 0) begin failed++; $display("FAIL ovr_ferr: got %0d, required 0", ferr_cnt - s_ferr); end
    idle(10);
  endtask

  task automatic test_back_to_back();
    snap();
    rx.rx_ready = 1'b0;
    exp_q.push_back(8'h44); send_byte(8'h44, 1'b1);
    idle(20);
    exp_q.push_back(8'h99);
    fork
      send_byte(8'h99, 1'b1);
      begin
        repeat (DONE_LAT - 1) @(posedge clk);
        @(negedge clk); rx.rx_ready = 1'b1;
        @(negedge clk); rx.rx_ready = 1'b0;
      end
    join
    #1;
    tests_run++; if (rx.rx_data !== 8'h99)   begin failed++; $display("FAIL b2b_data: got %02h, required 99", rx.rx_data); end
    tests_run++; if (rx.rx_valid !== 1'b1)   begin failed++; $display("FAIL b2b_valid: got %b, required 1", rx.rx_valid); end
    tests_run++; if (rise_cnt - s_rise != 1) begin failed++; $display("FAIL b2b_rises: got %0d, required 1", rise_cnt - s_rise); end
    tests_run++; if (ovr_cnt - s_ovr != 0)   begin failed++; $display("FAIL b2b_ovr: got %0d, required 0", ovr_cnt - s_ovr); end
    @(negedge clk);
    rx.rx_ready = 1'b1;
    idle(3);
    tests_run++; if (exp_q.size() != 0)      begin failed++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); end
    tests_run++; if (ferr_cnt - s_ferr != 0) begin failed++; $display("FAIL b2b_ferr: got %0d, required 0", ferr_cnt - s_ferr); end
  endtask

  task automatic test_reset_mid_frame();
    idle(10);
    snap();
    fork
      send_byte(8'hF0, 1'b1);
      begin
        repeat (5 * BIT_CLKS + 4) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests_run++; if (rx.rx_data !== 8'h00) begin failed++; $display("FAIL midrst_data: got %02h, required 00", rx.rx_data); end
        tests_run++; if (rx.rx_valid !== 1'b0 || rx.framing_err !== 1'b0 || rx.overrun !== 1'b0) begin
          failed++; $display("FAIL midrst_flags: got v%b f%b o%b, required 000", rx.rx_valid, rx.framing_err, rx.overrun);
        end
        tests_run++; if (state_dbg !== IDLE) begin failed++; $display("FAIL midrst_state: got %0d, required %0d", state_dbg, IDLE); end
        @(negedge clk);
        reset = 1'b0;
      end
    join
    idle(20);
    exp_q.push_back(8'h5A); send_byte(8'h5A, 1'b1);
    idle(40);
    tests_run++; if (exp_q.size() != 0)      begin failed++; $display("FAIL midrst_drain: got %0d pending, required 0", exp_q.size()); end
    tests_run++; if (rise_cnt - s_rise != 1) begin failed++; $display("FAIL midrst_rises: got %0d, required 1", rise_cnt - s_rise); end
    tests_run++; if (ferr_cnt - s_ferr != 0 || ovr_cnt - s_ovr != 0) begin failed++; $display("FAIL midrst_pulses: got ferr %0d ovr %0d, required 0 0", ferr_cnt - s_ferr, ovr_cnt - s_ovr); end
  endtask

  initial begin
    reset = 1'b1;
    line = 1'b1;
    rx.rx_ready = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
